board_lock_ctl: RTL and testbench

- Playfield owner for the falling-block game. It is the consumer end of the piece controller's lock handshake.
- On a lock request it stamps the active piece's four squares into the grid, then clears full rows and compacts the grid.
- It reports a per-lock line count for scoring.
- It returns grid-aware collision flags to the piece controller and a registered cell read port to the VGA draw path.

---
 rtl/board_lock_ctl_pkg.sv | 28 ++
 rtl/board_lock_ctl_if.sv | 28 ++
 rtl/board_row_full.sv | 18 +
 rtl/board_lock_ctl.sv | 178 +++++++++++++++++
 tb/tb_board_lock_ctl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/board_lock_ctl_pkg.sv
// Shared block codes, playfield defaults and cell-code helpers for the board lock controller.
package board_lock_ctl_pkg;
  localparam int COLS_DEF = 10;
  localparam int ROWS_DEF = 20;
  localparam int ID_W_DEF = 3;

  localparam logic [4:0] I_BLOCK = 5'b10000;
  localparam logic [4:0] O_BLOCK = 5'b10001;
  localparam logic [4:0] T_BLOCK = 5'b10010;
  localparam logic [4:0] S_BLOCK = 5'b10011;
  localparam logic [4:0] Z_BLOCK = 5'b10100;
  localparam logic [4:0] J_BLOCK = 5'b10101;
  localparam logic [4:0] L_BLOCK = 5'b10110;

  localparam logic [2:0] EMPTY_CELL = 3'd0;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_SCAN, S_SHIFT, S_DONE} state_t;

  // Unknown piece codes still land as a visible block (code 7).
  function automatic logic [2:0] cell_code(input logic [4:0] blk);
    if (blk >= I_BLOCK && blk <= L_BLOCK) return 3'(blk - I_BLOCK + 5'd1);
    return 3'd7;
  endfunction

  function automatic logic [2:0] sat_lines(input logic [2:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction
endpackage

// File: rtl/board_lock_ctl_if.sv
// Lock handshake and collision feedback between the piece controller and the board.
interface board_lock_ctl_if;
  logic       lock_en;
  logic [4:0] block;
  logic [3:0] sq_1_col, sq_2_col, sq_3_col, sq_4_col;
  logic [4:0] sq_1_row, sq_2_row, sq_3_row, sq_4_row;
  logic       collision;
  logic       blocked_left;
  logic       blocked_right;
  logic       busy;
  logic       line_valid;
  logic [2:0] lines_cleared;
  logic       game_over;

  modport master (
    output lock_en, block, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
           sq_1_row, sq_2_row, sq_3_row, sq_4_row,
    input  collision, blocked_left, blocked_right, busy, line_valid,
           lines_cleared, game_over
  );

  modport slave (
    input  lock_en, block, sq_1_col, sq_2_col, sq_3_col, sq_4_col,
           sq_1_row, sq_2_row, sq_3_row, sq_4_row,
    output collision, blocked_left, blocked_right, busy, line_valid,
           lines_cleared, game_over
  );
endinterface

// File: rtl/board_row_full.sv
// Row-full reduction: high when every cell of the row holds a block.
module board_row_full
  import board_lock_ctl_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic [COLS-1:0][ID_W-1:0] row_i,
  output logic                      full_o
);
  localparam int CW = $clog2(COLS);

  always_comb begin
    full_o = 1'b1;
    for (int c = 0; c < COLS; c++)
      if (row_i[CW'(c)] == ID_W'(EMPTY_CELL)) full_o = 1'b0;
  end
endmodule

// File: rtl/board_lock_ctl.sv
// Playfield owner: stamps locked pieces, clears and compacts full rows, serves
// collision flags to the piece controller and a registered read port to VGA.
module board_lock_ctl
  import board_lock_ctl_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             clear,
  board_lock_ctl_if.slave  pc,
  input  logic [3:0]       rd_col,
  input  logic [4:0]       rd_row,
  output logic [ID_W-1:0]  rd_cell
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  typedef logic [COLS-1:0][ID_W-1:0] row_t;

  row_t [ROWS-1:0]  grid_q, grid_d;
  state_t           state_q, state_d;
  logic [RW-1:0]    ptr_q, ptr_d;
  logic [2:0]       cnt_q, cnt_d, lines_q, lines_d;
  logic             go_q, go_d;
  logic [ID_W-1:0]  code_q, code_d, rd_q, rd_d;
  logic [3:0][3:0]  col_q, col_d, sq_col;
  logic [3:0][4:0]  row_q, row_d, sq_row;
  row_t             sel_row;
  logic             row_full, busy;
  logic             coll, blk_l, blk_r;

  assign sq_col = {pc.sq_4_col, pc.sq_3_col, pc.sq_2_col, pc.sq_1_col};
  assign sq_row = {pc.sq_4_row, pc.sq_3_row, pc.sq_2_row, pc.sq_1_row};
  assign busy   = (state_q != S_IDLE);

  function automatic logic occ(input int r, input int c);
    if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 1'b0;
    return |grid_q[RW'(r)][CW'(c)];
  endfunction

  // During SHIFT the row about to drop into ptr is tested, so a cleared row
  // costs a single cycle instead of a shift plus a re-scan.
  always_comb begin
    sel_row = grid_q[ptr_q];
    if (state_q == S_SHIFT) sel_row = (ptr_q == '0) ? '0 : grid_q[ptr_q - 1'b1];
  end

  board_row_full #(.COLS(COLS), .ID_W(ID_W)) u_row_full (
    .row_i  (sel_row),
    .full_o (row_full)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    lines_d = lines_q;
    go_d    = go_q;
    code_d  = code_q;
    col_d   = col_q;
    row_d   = row_q;
    grid_d  = grid_q;
    case (state_q)
      S_IDLE: if (pc.lock_en) begin
        code_d  = ID_W'(cell_code(pc.block));
        col_d   = sq_col;
        row_d   = sq_row;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        for (int i = 0; i < 4; i++) begin
          if (int'(col_q[i]) < COLS && int'(row_q[i]) < ROWS)
            grid_d[RW'(row_q[i])][CW'(col_q[i])] = code_q;
          if (row_q[i] == '0) go_d = 1'b1;
        end
        ptr_d   = RW'(ROWS - 1);
        cnt_d   = '0;
        state_d = S_SCAN;
      end
      S_SCAN: begin
        if (row_full) state_d = S_SHIFT;
        else if (ptr_q == '0) begin
          lines_d = sat_lines(cnt_q);
          state_d = S_DONE;
        end else ptr_d = ptr_q - 1'b1;
      end
      S_SHIFT: begin
        for (int r = 1; r < ROWS; r++)
          if (r <= int'(ptr_q)) grid_d[RW'(r)] = grid_q[RW'(r - 1)];
        grid_d[0] = '0;
        cnt_d = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
        if (row_full) state_d = S_SHIFT;
        else if (ptr_q == '0) begin
          lines_d = sat_lines(cnt_d);
          state_d = S_DONE;
        end else begin
          ptr_d   = ptr_q - 1'b1;
          state_d = S_SCAN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clear) begin
      grid_d  = '0;
      go_d    = 1'b0;
      lines_d = '0;
      state_d = S_IDLE;
    end
  end

  always_comb begin
    rd_d = '0;
    if (int'(rd_row) < ROWS && int'(rd_col) < COLS) rd_d = grid_q[RW'(rd_row)][CW'(rd_col)];
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      grid_q  <= '0;
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      lines_q <= '0;
      go_q    <= 1'b0;
      code_q  <= '0;
      col_q   <= '0;
      row_q   <= '0;
      rd_q    <= '0;
    end else begin
      grid_q  <= grid_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      lines_q <= lines_d;
      go_q    <= go_d;
      code_q  <= code_d;
      col_q   <= col_d;
      row_q   <= row_d;
      rd_q    <= rd_d;
    end
  end

  // Flags look at the live squares; the grid is in flux while busy, so mask them.
  always_comb begin
    int r, c;
    coll  = 1'b0;
    blk_l = 1'b0;
    blk_r = 1'b0;
    r = 0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      r = int'(sq_row[i]);
      c = int'(sq_col[i]);
      if (r < ROWS && c < COLS) begin
        if (r == ROWS - 1 || occ(r + 1, c)) coll  = 1'b1;
        if (c == 0 || occ(r, c - 1))        blk_l = 1'b1;
        if (c == COLS - 1 || occ(r, c + 1)) blk_r = 1'b1;
      end
    end
    if (busy) begin
      coll  = 1'b0;
      blk_l = 1'b0;
      blk_r = 1'b0;
    end
  end

  assign pc.collision     = coll;
  assign pc.blocked_left  = blk_l;
  assign pc.blocked_right = blk_r;
  assign pc.busy          = busy;
  assign pc.line_valid    = (state_q == S_DONE);
  assign pc.lines_cleared = lines_q;
  assign pc.game_over     = go_q;
  assign rd_cell          = rd_q;
endmodule

// File: tb/tb_board_lock_ctl.sv
// Scoreboard bench: lock and read requests queue expectations, a negedge monitor checks them.
module tb_board_lock_ctl;
  import board_lock_ctl_pkg::*;
  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic [3:0] rd_col = '0;
  logic [4:0] rd_row = '0;
  logic [2:0] rd_cell;

  board_lock_ctl_if pc();

  board_lock_ctl dut (
    .pclk    (pclk),
    .rst     (rst),
    .clear   (clear),
    .pc      (pc),
    .rd_col  (rd_col),
    .rd_row  (rd_row),
    .rd_cell (rd_cell)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [2:0] lines;
    int         cyc;
  } lexp_t;

  lexp_t      lq[$];
  logic [2:0] rq[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  logic       rd_req = 1'b0;
  logic       rd_pend = 1'b0;

  always @(posedge pclk) begin
    cyc     <= cyc + 1;
    rd_pend <= rd_req;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge pclk) begin : mon
    lexp_t e;
    if (pc.line_valid === 1'b1) begin
      if (lq.size() == 0) chk("line_valid with no lock pending", pc.line_valid, 0);
      else begin
        e = lq.pop_front();
        chk("lines_cleared", pc.lines_cleared, e.lines);
        chk("lock latency", cyc, e.cyc);
      end
    end
    if (rd_pend) begin
      if (rq.size() == 0) chk("read with no request pending", rd_pend, 0);
      else chk("rd_cell", rd_cell, rq.pop_front());
    end
  end

  task automatic set_sq(input int r1, c1, r2, c2, r3, c3, r4, c4);
    pc.sq_1_row = 5'(r1); pc.sq_1_col = 4'(c1);
    pc.sq_2_row = 5'(r2); pc.sq_2_col = 4'(c2);
    pc.sq_3_row = 5'(r3); pc.sq_3_col = 4'(c3);
    pc.sq_4_row = 5'(r4); pc.sq_4_col = 4'(c4);
  endtask

  // Latency counted from the cycle lock_en is high to the line_valid cycle.
  task automatic lock(input logic [4:0] blk, input bit push, input int lines);
    @(negedge pclk);
    pc.block   = blk;
    pc.lock_en = 1'b1;
    if (push) lq.push_back('{lines: 3'(lines), cyc: cyc + ROWS + 2 + lines});
    @(posedge pclk);
    #1 pc.lock_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge pclk);
    while (pc.busy === 1'b1 && n < 200) begin
      @(negedge pclk);
      n++;
    end
    if (n >= 200) chk("busy timeout", pc.busy, 0);
  endtask

  task automatic lockw(input logic [4:0] blk, input int lines);
    lock(blk, 1'b1, lines);
    wait_idle();
  endtask

  task automatic clear_pulse();
    @(negedge pclk);
    clear = 1'b1;
    @(posedge pclk);
    #1 clear = 1'b0;
  endtask

  task automatic rd_chk(input int r, input int c, input int exp);
    @(negedge pclk);
    rd_row = 5'(r);
    rd_col = 4'(c);
    rd_req = 1'b1;
    rq.push_back(3'(exp));
    @(posedge pclk);
    #1 rd_req = 1'b0;
  endtask

  // Square k sits at (r,c); the other three sit at a free spot (3,7).
  task automatic flags(input string nm, input int r, input int c, input int k,
                       input logic ec, input logic el, input logic er);
    @(negedge pclk);
    set_sq(3, 7, 3, 7, 3, 7, 3, 7);
    case (k)
      0: begin pc.sq_1_row = 5'(r); pc.sq_1_col = 4'(c); end
      1: begin pc.sq_2_row = 5'(r); pc.sq_2_col = 4'(c); end
      2: begin pc.sq_3_row = 5'(r); pc.sq_3_col = 4'(c); end
      default: begin pc.sq_4_row = 5'(r); pc.sq_4_col = 4'(c); end
    endcase
    #1;
    chk({nm, " collision"}, pc.collision, ec);
    chk({nm, " blocked_left"}, pc.blocked_left, el);
    chk({nm, " blocked_right"}, pc.blocked_right, er);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pc.lock_en = 1'b0;
    pc.block   = I_BLOCK;
    set_sq(5, 5, 5, 5, 5, 5, 5, 5);
    repeat (3) @(posedge pclk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge pclk);
    chk("reset busy", pc.busy, 0);
    chk("reset line_valid", pc.line_valid, 0);
    chk("reset lines_cleared", pc.lines_cleared, 0);
    chk("reset game_over", pc.game_over, 0);
    chk("reset rd_cell", rd_cell, 0);
    chk("reset collision", pc.collision, 0);
    chk("reset blocked_left", pc.blocked_left, 0);
    chk("reset blocked_right", pc.blocked_right, 0);

    // Horizontal I on the floor, no line
    set_sq(19, 3, 19, 4, 19, 5, 19, 6);
    lockw(I_BLOCK, 0);
    chk("floor I game_over", pc.game_over, 0);
    for (int c = 3; c <= 6; c++) rd_chk(19, c, 1);
    rd_chk(19, 2, 0);
    rd_chk(19, 7, 0);

    // Fill the rest of row 19; the L completes it and its upper cells drop by one
    set_sq(19, 0, 19, 1, 19, 2, 19, 9);
    lockw(T_BLOCK, 0);
    set_sq(19, 7, 19, 8, 18, 7, 17, 7);
    lockw(L_BLOCK, 1);
    chk("lines_cleared holds", pc.lines_cleared, 1);
    rd_chk(19, 7, 7);
    rd_chk(18, 7, 7);
    rd_chk(17, 7, 0);
    rd_chk(19, 0, 0);
    rd_chk(19, 8, 0);
    rd_chk(19, 3, 0);
    clear_pulse();

    // Rows 16..19 full except col 9; off-grid padding squares must be skipped
    for (int r = 16; r <= 19; r++) begin
      set_sq(r, 0, r, 1, r, 2, r, 3);
      lockw(S_BLOCK, 0);
      set_sq(r, 4, r, 5, r, 6, r, 7);
      lockw(S_BLOCK, 0);
      set_sq(r, 8, r, 15, r, 15, r, 15);
      lockw(S_BLOCK, 0);
    end
    rd_chk(16, 8, 4);
    rd_chk(16, 9, 0);
    set_sq(16, 9, 17, 9, 18, 9, 19, 9);
    lockw(I_BLOCK, 4);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) rd_chk(r, c, 0);

    // Lock ignored while busy, then clear aborts the sequence mid-scan
    set_sq(5, 0, 5, 1, 5, 2, 5, 3);
    lock(J_BLOCK, 1'b0, 0);
    @(posedge pclk);
    @(negedge pclk);
    set_sq(19, 2, 19, 2, 19, 2, 19, 2);
    pc.lock_en = 1'b1;
    @(posedge pclk);
    #1 pc.lock_en = 1'b0;
    @(negedge pclk);
    chk("busy during scan", pc.busy, 1);
    chk("collision masked while busy", pc.collision, 0);
    chk("lines_cleared held while busy", pc.lines_cleared, 4);
    clear_pulse();
    @(negedge pclk);
    chk("busy after clear", pc.busy, 0);
    chk("line_valid after clear", pc.line_valid, 0);
    chk("lines_cleared after clear", pc.lines_cleared, 0);
    chk("floor collision when idle", pc.collision, 1);
    rd_chk(5, 0, 0);
    rd_chk(5, 3, 0);
    repeat (30) @(negedge pclk);
    chk("second lock not queued", pc.busy, 0);

    // Grid-aware flags around an occupied cell at (10,4)
    set_sq(10, 4, 10, 15, 10, 15, 10, 15);
    lockw(T_BLOCK, 0);
    flags("above occ", 9, 4, 0, 1, 0, 0);
    flags("right of occ", 10, 5, 1, 0, 1, 0);
    flags("left of occ", 10, 3, 2, 0, 0, 1);
    flags("floor row", 19, 2, 3, 1, 0, 0);
    flags("col 0", 5, 0, 0, 0, 1, 0);
    flags("col max", 5, 9, 1, 0, 0, 1);
    flags("off row", 20, 4, 2, 0, 0, 0);
    flags("off col", 9, 12, 3, 0, 0, 0);

    // game_over is sticky across locks; unknown block code stores 7
    set_sq(0, 4, 0, 5, 1, 5, 1, 6);
    lockw(Z_BLOCK, 0);
    chk("game_over set", pc.game_over, 1);
    set_sq(19, 0, 18, 0, 5, 15, 5, 15);
    lockw(5'b11111, 0);
    chk("game_over sticky", pc.game_over, 1);
    rd_chk(19, 0, 7);
    rd_chk(18, 0, 7);
    rd_chk(0, 4, 5);
    rd_chk(1, 6, 5);
    clear_pulse();
    @(negedge pclk);
    chk("game_over after clear", pc.game_over, 0);
    rd_chk(0, 4, 0);

    // Reset landing in SHIFT returns every output to zero
    set_sq(19, 0, 19, 1, 19, 2, 19, 3);
    lockw(I_BLOCK, 0);
    set_sq(19, 4, 19, 5, 19, 6, 19, 7);
    lockw(I_BLOCK, 0);
    rd_chk(19, 0, 1);
    set_sq(19, 8, 19, 9, 0, 0, 0, 0);
    lock(O_BLOCK, 1'b0, 0);
    @(posedge pclk);
    @(posedge pclk);
    @(negedge pclk);
    chk("busy in shift", pc.busy, 1);
    chk("game_over before rst", pc.game_over, 1);
    chk("rd_cell before rst", rd_cell, 1);
    rst = 1'b1;
    set_sq(5, 5, 5, 5, 5, 5, 5, 5);
    @(posedge pclk);
    @(negedge pclk);
    chk("rst busy", pc.busy, 0);
    chk("rst line_valid", pc.line_valid, 0);
    chk("rst lines_cleared", pc.lines_cleared, 0);
    chk("rst game_over", pc.game_over, 0);
    chk("rst rd_cell", rd_cell, 0);
    chk("rst collision", pc.collision, 0);
    chk("rst blocked_left", pc.blocked_left, 0);
    chk("rst blocked_right", pc.blocked_right, 0);
    rst = 1'b0;
    rd_chk(19, 0, 0);
    rd_chk(0, 0, 0);

    repeat (3) @(negedge pclk);
    chk("line events outstanding", lq.size(), 0);
    chk("reads outstanding", rq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
